// File: rtl/button_debouncer_pkg.sv
// Shared types for the board-input conditioning blocks.
package input_pkg;

  // Debouncer state: settled low, qualifying a rise, settled high,
  // qualifying a fall.
  typedef enum logic [1:0] {
    LOW       = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } debounce_state_t;

  // Width of the hold timer: it must reach max(delay, period) without wrapping.
  function automatic int hcnt_width(input int repeatDelay, input int repeatPeriod);
    int largest;
    largest = (repeatDelay > repeatPeriod) ? repeatDelay : repeatPeriod;
    return $clog2(largest + 1);
  endfunction

endpackage

// File: rtl/button_debouncer_hold_timer.sv
// Hold timer: measures how long the debounced level has been held high and
// emits registered auto-repeat ticks (first after REPEAT_DELAY, then every
// REPEAT_PERIOD cycles of accumulated high time).
import input_pkg::*;

module hold_timer #(
  parameter int REPEAT_DELAY  = 0,
  parameter int REPEAT_PERIOD = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int HW = hcnt_width(REPEAT_DELAY, REPEAT_PERIOD);

  // Count value at which the first tick fires, and at which later ticks fire
  // once the counter has been reloaded to zero after a tick.
  localparam logic [HW-1:0] FIRST_LAST  = HW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [HW-1:0] PERIOD_LAST = HW'(REPEAT_PERIOD - 1);
  localparam bit            ENABLE      = (REPEAT_DELAY != 0);

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          repeating_q, repeating_d;
  logic          tick_q, tick_d;
  logic [HW-1:0] targetCount;

  // Pick the terminal count: the first tick uses the delay, later ones the period.
  always_comb begin
    targetCount = repeating_q ? PERIOD_LAST : FIRST_LAST;
  end

  // Next-state logic: clear wins, otherwise count only while running; the
  // counter reloads on a tick and never counts past its terminal value.
  always_comb begin
    hcnt_d      = hcnt_q;
    repeating_d = repeating_q;
    tick_d      = 1'b0;
    if (clear_i) begin
      hcnt_d      = '0;
      repeating_d = 1'b0;
    end else if (run_i && ENABLE) begin
      if (hcnt_q == targetCount) begin
        tick_d      = 1'b1;
        hcnt_d      = '0;
        repeating_d = 1'b1;
      end else if (hcnt_q < targetCount) begin
        hcnt_d = hcnt_q + HW'(1);
      end
    end
  end

  // Timer and tick registers; reset discards any pending repeat immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt_q      <= '0;
      repeating_q <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      hcnt_q      <= hcnt_d;
      repeating_q <= repeating_d;
      tick_q      <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/button_debouncer.sv
// Button debouncer: turns a synchronized, bouncy board input into a clean
// level plus one-cycle press/release/repeat pulses, all driven from flops.
import input_pkg::*;

module button_debouncer #(
  parameter int STABLE_CYCLES = 16,
  parameter int REPEAT_DELAY  = 0,
  parameter int REPEAT_PERIOD = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic in_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);

  localparam int              CNT_W    = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  debounce_state_t  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             holdRun;
  logic             holdClear;
  logic             repeatTick;

  // Debounce FSM: a level change is accepted only after STABLE_CYCLES
  // identical samples; any contrary sample abandons the qualification.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    unique case (state_q)
      LOW: begin
        cnt_d = '0;
        if (in_i) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT_HIGH: begin
        if (!in_i) begin
          state_d = LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HIGH;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HIGH: begin
        cnt_d = '0;
        if (!in_i) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT_LOW: begin
        if (in_i) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = LOW;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = LOW;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  // State, stability counter and output registers; reset forces every
  // output low immediately and drops any qualification in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= LOW;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Hold timer control: it runs only while settled high (so WAIT_LOW
  // excursions freeze it), restarts on a fresh press, and is held clear in LOW.
  always_comb begin
    holdRun   = (state_q == HIGH);
    holdClear = press_d || (state_q == LOW);
  end

  hold_timer #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_hold_timer (
    .clk    (clk),
    .rst    (rst),
    .run_i  (holdRun),
    .clear_i(holdClear),
    .tick_o (repeatTick)
  );

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign repeat_o  = repeatTick;

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer: stimulus pushes expected pulses
// (kind and edge index) into a queue, monitors pop and compare on each pulse.
module tb_button_debouncer;

  localparam int KIND_PRESS   = 1;
  localparam int KIND_RELEASE = 2;
  localparam int KIND_REPEAT  = 4;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic clk;
  logic rst;
  logic inA, inB;
  logic levelA, pressA, releaseA, repeatA;
  logic levelB, pressB, releaseB, repeatB;

  int   cyc;
  int   total;
  int   bad;
  int   repeatCountB;
  ev_t  expQ[$];
  ev_t  expQB[$];

  button_debouncer #(
    .STABLE_CYCLES(4),
    .REPEAT_DELAY (10),
    .REPEAT_PERIOD(5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_i     (inA),
    .level_o  (levelA),
    .press_o  (pressA),
    .release_o(releaseA),
    .repeat_o (repeatA)
  );

  button_debouncer #(
    .STABLE_CYCLES(4),
    .REPEAT_DELAY (0),
    .REPEAT_PERIOD(5)
  ) dutNoRepeat (
    .clk      (clk),
    .rst      (rst),
    .in_i     (inB),
    .level_o  (levelB),
    .press_o  (pressB),
    .release_o(releaseB),
    .repeat_o (repeatB)
  );

  // 20-time-unit clock
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Edge index: after rising edge n (and before the next), cyc == n
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, wanted %0d (edge %0d)", name, actual, expected, cyc);
    end
  endtask

  // Drive both inputs for n sampling edges; returns #1 after the last edge
  task automatic applyStimulus(input logic valA, input logic valB, input int n);
    repeat (n) begin
      inA = valA;
      inB = valB;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic countDue(output int n);
    n = 0;
    foreach (expQ[i]) if (expQ[i].cyc <= cyc) n++;
  endtask

  // Monitor for the repeating instance
  always @(negedge clk) begin
    int kind;
    ev_t e;
    if (!rst) begin
      kind = int'(pressA) + 2 * int'(releaseA) + 4 * int'(repeatA);
      if (kind != 0) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected pulse A", kind, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("pulse kind A", kind, e.kind);
          checkOutput("pulse edge A", cyc, e.cyc);
        end
      end
    end
  end

  // Monitor for the REPEAT_DELAY=0 instance
  always @(negedge clk) begin
    int kind;
    ev_t e;
    if (!rst) begin
      kind = int'(pressB) + 2 * int'(releaseB) + 4 * int'(repeatB);
      if (repeatB) repeatCountB++;
      if (kind != 0) begin
        if (expQB.size() == 0) begin
          checkOutput("unexpected pulse B", kind, 0);
        end else begin
          e = expQB.pop_front();
          checkOutput("pulse kind B", kind, e.kind);
          checkOutput("pulse edge B", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    int k;
    int p;
    int due;
    total        = 0;
    bad          = 0;
    repeatCountB = 0;
    rst = 1'b1;
    inA = 1'b0;
    inB = 1'b0;

    // Reset values, visible before any clock edge
    #5;
    checkOutput("reset level", int'(levelA), 0);
    checkOutput("reset press", int'(pressA), 0);
    checkOutput("reset release", int'(releaseA), 0);
    checkOutput("reset repeat", int'(repeatA), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Bounce rejection: three high samples are one short of qualifying
    applyStimulus(1'b1, 1'b0, 3);
    checkOutput("bounce level mid", int'(levelA), 0);
    applyStimulus(1'b0, 1'b0, 4);
    checkOutput("bounce level after", int'(levelA), 0);

    // Clean press at first-sample+3, repeats 10/15/20 edges later
    k = cyc + 1;
    p = k + 3;
    expQ.push_back('{kind: KIND_PRESS,  cyc: p});
    expQ.push_back('{kind: KIND_REPEAT, cyc: p + 10});
    expQ.push_back('{kind: KIND_REPEAT, cyc: p + 15});
    expQ.push_back('{kind: KIND_REPEAT, cyc: p + 20});
    applyStimulus(1'b1, 1'b0, 3);
    checkOutput("level before 4th sample", int'(levelA), 0);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("level after 4th sample", int'(levelA), 1);
    applyStimulus(1'b1, 1'b0, 21);

    // Release with bounce: 0,0,1 then low; release on 4th consecutive low
    expQ.push_back('{kind: KIND_RELEASE, cyc: k + 31});
    applyStimulus(1'b0, 1'b0, 2);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("level during release bounce", int'(levelA), 1);
    applyStimulus(1'b0, 1'b0, 3);
    checkOutput("level before release", int'(levelA), 1);
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("level after release", int'(levelA), 0);
    applyStimulus(1'b0, 1'b0, 12);
    checkOutput("pending after release", expQ.size(), 0);

    // Async reset while held high, between the first and second repeat
    k = cyc + 1;
    p = k + 3;
    expQ.push_back('{kind: KIND_PRESS,  cyc: p});
    expQ.push_back('{kind: KIND_REPEAT, cyc: p + 10});
    applyStimulus(1'b1, 1'b0, 15);
    checkOutput("level before reset", int'(levelA), 1);
    #4;
    countDue(due);
    checkOutput("pulses due before reset", due, 0);
    expQ.delete();
    rst = 1'b1;
    #1;
    checkOutput("async reset level", int'(levelA), 0);
    checkOutput("async reset press", int'(pressA), 0);
    checkOutput("async reset release", int'(releaseA), 0);
    checkOutput("async reset repeat", int'(repeatA), 0);
    @(posedge clk);
    @(posedge clk);
    #5;
    rst = 1'b0;

    // Fresh press after reset with input still high, then release
    k = cyc + 1;
    expQ.push_back('{kind: KIND_PRESS,   cyc: k + 3});
    expQ.push_back('{kind: KIND_RELEASE, cyc: k + 9});
    applyStimulus(1'b1, 1'b0, 6);
    checkOutput("level after post-reset press", int'(levelA), 1);
    applyStimulus(1'b0, 1'b0, 6);
    checkOutput("level after post-reset release", int'(levelA), 0);
    checkOutput("pending after post-reset", expQ.size(), 0);

    // REPEAT_DELAY=0 instance: 50 high samples give one press, no repeat
    k = cyc + 1;
    expQB.push_back('{kind: KIND_PRESS,   cyc: k + 3});
    expQB.push_back('{kind: KIND_RELEASE, cyc: k + 53});
    applyStimulus(1'b0, 1'b1, 50);
    checkOutput("no-repeat level held", int'(levelB), 1);
    applyStimulus(1'b0, 1'b0, 6);
    checkOutput("no-repeat level released", int'(levelB), 0);
    checkOutput("no-repeat repeat count", repeatCountB, 0);
    checkOutput("no-repeat pending", expQB.size(), 0);
    checkOutput("idle instance level", int'(levelA), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Debounces one already-synchronized board input (push-button or switch) and turns it into a clean level plus single-cycle event pulses. Sits directly downstream of the two-flop input synchronizer: its `in` is that synchronizer's `out`, and it runs on the same clock. Its outputs feed the control logic that starts, stops and steps the DFT engine. A held button additionally produces auto-repeat pulses.

## Interface
- `STABLE_CYCLES`, default 16 — consecutive identical samples needed to accept a level change; legal range ≥ 2 (use ~500000 on hardware at 50 MHz).
- `REPEAT_DELAY`, default 0 — cycles from `press` to the first `repeat`; 0 disables auto-repeat.
- `REPEAT_PERIOD`, default 8 — cycles between successive `repeat` pulses; legal range ≥ 1.

- `clk`  input  1  — system clock; the only clock.
- `rst`  input  1  — reset, asynchronous, active-high.
- `in`  input  1  — synchronized raw input; never sampled asynchronously.
- `level`  output  1  — debounced level.
- `press`  output  1  — one-cycle pulse when `level` goes 0→1.
- `release`  output  1  — one-cycle pulse when `level` goes 1→0.
- `repeat`  output  1  — one-cycle auto-repeat pulse while held.

## Operation
- State machine states: LOW, WAIT_HIGH, HIGH, WAIT_LOW.
- Stability counter `cnt`:
  - Width is `$clog2(STABLE_CYCLES)`.
  - Cleared on every state change unless stated otherwise.
- From LOW:
  - `in`=1 → WAIT_HIGH, with `cnt`←1.
- From WAIT_HIGH:
  - `in`=0 → LOW.
  - `in`=1 and `cnt`=STABLE_CYCLES-1 → HIGH; `level`←1; `press` pulses.
  - Otherwise `cnt`++.
- From HIGH:
  - `in`=0 → WAIT_LOW, with `cnt`←1.
- From WAIT_LOW:
  - `in`=1 → HIGH. No pulse; the hold timer resumes.
  - `in`=0 and `cnt`=STABLE_CYCLES-1 → LOW; `level`←0; `release` pulses.
  - Otherwise `cnt`++.
- Hold timer `hcnt`:
  - Width is `$clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1)`.
  - Cleared on entry to HIGH from WAIT_HIGH.
  - Counts only in HIGH, is frozen in WAIT_LOW, and is cleared in LOW.
- Repeat pulses:
  - `repeat` pulses when `hcnt` reaches REPEAT_DELAY-1 the first time.
  - After each pulse `hcnt` reloads so that the next pulse follows REPEAT_PERIOD cycles later.
  - Never pulses if REPEAT_DELAY=0.
- Pulse exclusivity:
  - `press`, `release` and `repeat` are registered and mutually exclusive.
  - `repeat` never coincides with `press`.
- Counters saturate by construction; there is no wrap-around path.

## Timing
- Reset:
  - `rst` high clears state to LOW and clears `cnt` and `hcnt`.
  - It forces `level`, `press`, `release` and `repeat` to 0 immediately, without waiting for a clock edge.
  - Reset mid-operation discards any pending qualification or repeat.
  - The first sample is taken on the first `clk` rising edge after `rst` deasserts.
- Press latency:
  - If `in` is first sampled 1 at edge k and stays 1, then `level` and `press` are 1 after edge k+STABLE_CYCLES-1.
  - `press` returns to 0 after the next edge.
- Release latency is symmetric: STABLE_CYCLES consecutive low samples are required.
- Bounce shorter than STABLE_CYCLES samples produces no output change and no pulse.
- Repeat timing:
  - The first `repeat` pulses REPEAT_DELAY cycles after the `press` pulse.
  - Subsequent pulses occur every REPEAT_PERIOD cycles, plus the number of cycles spent in WAIT_LOW excursions.
- End-to-end latency from the pin is 2 synchronizer cycles plus STABLE_CYCLES.

## Structure
- Shared package `input_pkg` holds `debounce_state_t`, an enum of LOW, WAIT_HIGH, HIGH and WAIT_LOW.
- One sub-module, `hold_timer`, implements `hcnt` and the repeat-pulse logic. It has inputs `clk`, `rst`, `run`, `clear` and output `tick`, and carries parameters REPEAT_DELAY and REPEAT_PERIOD.
- The FSM and stability counter live in `button_debouncer`.
- Outputs are driven directly from flops; there is no combinational path from `in` to any output.

## Test plan
Bench parameters: STABLE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5, clock period 20.
- Bounce rejection: `in`=1 for 3 cycles, then 0. Required: `level` stays 0, no `press`, state returns to LOW.
- Clean press: `in`=1 held. Required: `level`=1 and `press`=1 for exactly one cycle, after the 4th high sample.
- Auto-repeat: hold continues. Required: `repeat` pulses at 10, 15 and 20 cycles after `press`, each one cycle wide.
- Release with bounce: `in`=0 for 2 cycles, 1 for 1 cycle, then 0 held. Required: no pulse during the bounce; one `release` after the 4th consecutive low sample, then `level`=0 and no further `repeat`.
- Asynchronous reset:
  - Assert `rst` mid-cycle while in HIGH, between repeats. Required: all outputs 0 before the next `clk` edge.
  - After deassert with `in`=1: a fresh `press` after 4 samples.
- REPEAT_DELAY=0 instance: hold `in`=1 for 50 cycles. Required: exactly one `press`, zero `repeat`.
